arp_rx_parser: RTL and testbench
================================

ARP_RX_PARSER -- requirements
Module: arp_rx_parser

Interface
REQ-001 Parameter NUM_IP, default 2: number of local IPv4 addresses matched (legal 1..4).
REQ-002 Parameter CNT_W, default 16: width of the drop counter.
REQ-003 Parameter IDX_W, default (NUM_IP>1 ? $clog2(NUM_IP) : 1): width of the match index.
REQ-004 Port mac_gmii_rx_clk, input, 1: the only clock; all logic is on its rising edge.
REQ-005 Port mac_gmii_rx_rst, input, 1: asynchronous, active-high reset.
REQ-006 Port mac_gmii_rxd, input, 8: GMII receive byte.
REQ-007 Port mac_gmii_rx_dv, input, 1: receive data valid.
REQ-008 Port mac_gmii_rx_er, input, 1: receive error.
REQ-009 Port eth_type_arp_valid, input, 1: one-cycle pulse coincident with ARP payload byte 0 (HTYPE high byte).
REQ-010 Port local_ip, input, NUM_IP*32: local IPs; entry i occupies bits [32i+31:32i].
REQ-011 Port local_ip_en, input, NUM_IP: per-entry enable.
REQ-012 Port arp_valid, output, 1: event available.
REQ-013 Port arp_ready, input, 1: consumer accepts the event.
REQ-014 Port arp_oper, output, 1: 1 = request, 0 = reply.
REQ-015 Port arp_sha, output, 48, and arp_spa, output, 32: sender MAC and sender IP.
REQ-016 Port arp_ip_idx, output, IDX_W: index of the matched local IP.
REQ-017 Port arp_grat, output, 1: event is a gratuitous ARP.
REQ-018 Port arp_drop_cnt, output, CNT_W: saturating count of discarded ARP frames.

Function
REQ-019 States: IDLE, HDR (bytes 0-7), SENDER (bytes 8-17), TARGET (bytes 18-27), TAIL, DISCARD; a 5-bit byte counter indexes ARP bytes 0-27.
REQ-020 A byte is accepted when mac_gmii_rx_dv=1 and mac_gmii_rx_er=0.
REQ-021 IDLE->HDR when eth_type_arp_valid=1 with an accepted byte; that byte is byte 0.
REQ-022 HDR checks HTYPE=0x0001, PTYPE=0x0800, HLEN=0x06, PLEN=0x04 and OPER in {0x0001, 0x0002}, each at its final byte; any mismatch goes to DISCARD.
REQ-023 SENDER captures SHA (bytes 8-13) and SPA (bytes 14-17) MSB-first; TARGET ignores THA (bytes 18-23) and captures TPA (bytes 24-27).
REQ-024 After byte 27, TPA is compared against every entry with local_ip_en=1; the lowest matching index wins.
REQ-025 On a match, the event is loaded into the output register and arp_valid rises on the cycle after byte 27 (latency 1); on no match, the frame is dropped.
REQ-026 TAIL ignores padding and FCS until mac_gmii_rx_dv=0, then goes to IDLE.
REQ-027 mac_gmii_rx_dv falling in any state before byte 27 completes aborts the frame; the FSM returns to IDLE and the drop counter increments.
REQ-028 mac_gmii_rx_er=1 while mac_gmii_rx_dv=1 in HDR, SENDER or TARGET aborts the frame; the FSM goes to DISCARD and the drop counter increments.
REQ-029 DISCARD waits for mac_gmii_rx_dv=0, then goes to IDLE.
REQ-030 Header mismatch and no TPA match each increment arp_drop_cnt by 1.
REQ-031 arp_drop_cnt saturates at all-ones and never wraps.
REQ-032 The output is a single-entry register; all arp_* data fields are held stable while arp_valid=1 and arp_ready=0.
REQ-033 A new event completing while arp_valid=1 and arp_ready=0 is discarded: the register is unchanged and the drop counter increments.
REQ-034 A new event completing in the same cycle as arp_valid=1 and arp_ready=1 loads the new event; arp_valid stays 1.
REQ-035 arp_valid clears on arp_valid=1 and arp_ready=1 when no event completes in that cycle.
REQ-036 eth_type_arp_valid is ignored outside IDLE.

Reset
REQ-037 Reset drives the FSM to IDLE, the byte counter to 0, arp_valid to 0, arp_oper to 0, arp_sha to 0, arp_spa to 0, arp_ip_idx to 0, arp_grat to 0 and arp_drop_cnt to 0.
REQ-038 Reset asserted mid-frame discards the partial frame; after release the FSM waits in IDLE for a new eth_type_arp_valid.

Configuration
REQ-039 With ARP_RX_GRATUITOUS_EN defined, a frame with SPA==TPA is accepted regardless of the TPA match and is reported with arp_grat=1, arp_oper taken from OPER, and arp_ip_idx=0.
REQ-040 Without ARP_RX_GRATUITOUS_EN, gratuitous frames follow the normal TPA match rule, and arp_grat is tied to 0 (the port remains present).

Structure
REQ-041 Package arp_pkg holds:
- ARP_HTYPE_ETH, ARP_PTYPE_IPV4, ARP_HLEN, ARP_PLEN, ARP_OPER_REQ, ARP_OPER_REPLY;
- ARP_LEN=28;
- the parser state enum typedef.
REQ-042 Sub-module arp_ip_match is purely combinational: TPA, local_ip and local_ip_en in; hit and index out (lowest index wins).

Verification
REQ-043 Request: local_ip[0]=192.168.1.10, enabled; inject request with TPA=192.168.1.10, SHA=02:11:22:33:44:55 -> one arp_valid, arp_oper=1, arp_ip_idx=0, arp_sha=0x021122334455, latency 1 after byte 27.
REQ-044 Multi-IP reply: entries 0 and 1 both equal 10.0.0.5, both enabled; inject reply with TPA=10.0.0.5 -> arp_ip_idx=0 and arp_oper=0; then disable entry 0 and repeat -> arp_ip_idx=1.
REQ-045 Corruption: HTYPE=0x0006, or rx_er pulsed at byte 12, or rx_dv dropped at byte 20 -> no arp_valid, arp_drop_cnt +1 each, FSM in IDLE, and the next good frame is accepted.
REQ-046 Backpressure: arp_ready=0 during two back-to-back valid requests -> first event held and unchanged, second dropped (arp_drop_cnt +1); with arp_ready=1 in the completion cycle of the second frame -> second event replaces the first and arp_valid stays 1.
REQ-047 Gratuitous: SPA=TPA=172.16.0.9, no local match -> with ARP_RX_GRATUITOUS_EN, arp_valid=1 and arp_grat=1; without it, dropped and arp_drop_cnt +1.
REQ-048 Saturation and reset: CNT_W=2, inject 5 bad frames -> arp_drop_cnt=3; assert reset at byte 15 of a frame -> all outputs 0, and no event is produced from that frame.

Source files
------------

// File: rtl/arp_pkg.sv
// arp_pkg: ARP field constants, frame length and parser state encoding shared by the ARP receive path.
package arp_pkg;
    localparam logic [15:0] ARP_HTYPE_ETH  = 16'h0001;
    localparam logic [15:0] ARP_PTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  ARP_HLEN       = 8'h06;
    localparam logic [7:0]  ARP_PLEN       = 8'h04;
    localparam logic [15:0] ARP_OPER_REQ   = 16'h0001;
    localparam logic [15:0] ARP_OPER_REPLY = 16'h0002;
    localparam int          ARP_LEN        = 28;
    typedef enum logic [2:0] {IDLE, HDR, SENDER, TARGET, TAIL, DISCARD} arp_state_e;
endpackage

// File: rtl/arp_rx_parser_if.sv
// arp_rx_parser_if: ARP event bus (valid/ready handshake plus decoded fields) from parser to consumer.
interface arp_rx_parser_if #(parameter int IDX_W = 1);
    logic             arp_valid;
    logic             arp_ready;
    logic             arp_oper;
    logic [47:0]      arp_sha;
    logic [31:0]      arp_spa;
    logic [IDX_W-1:0] arp_ip_idx;
    logic             arp_grat;
    modport master(output arp_valid, arp_oper, arp_sha, arp_spa, arp_ip_idx, arp_grat, input arp_ready);
    modport slave(input arp_valid, arp_oper, arp_sha, arp_spa, arp_ip_idx, arp_grat, output arp_ready);
endinterface

// File: rtl/arp_ip_match.sv
// arp_ip_match: combinational compare of a target IP against enabled local IPs; lowest index wins.
module arp_ip_match #(
    parameter int NUM_IP = 2,
    parameter int IDX_W  = 1
) (
    input  logic [31:0]          tpa,
    input  logic [NUM_IP*32-1:0] local_ip,
    input  logic [NUM_IP-1:0]    local_ip_en,
    output logic                 hit,
    output logic [IDX_W-1:0]     idx
);
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = NUM_IP - 1; i >= 0; i--)
            if (local_ip_en[i] && local_ip[32*i +: 32] == tpa) begin
                hit = 1'b1;
                idx = IDX_W'(i);
            end
    end
endmodule

// File: rtl/arp_rx_parser.sv
// arp_rx_parser: parses ARP payload bytes from GMII, matches TPA against local IPs, emits one-entry event.
// Define ARP_RX_GRATUITOUS_EN to accept gratuitous ARP (SPA==TPA) regardless of local match.
module arp_rx_parser
    import arp_pkg::*;
#(
    parameter int NUM_IP = 2,
    parameter int CNT_W  = 16,
    parameter int IDX_W  = (NUM_IP > 1) ? $clog2(NUM_IP) : 1
) (
    input  logic                  mac_gmii_rx_clk,
    input  logic                  mac_gmii_rx_rst,
    input  logic [7:0]            mac_gmii_rxd,
    input  logic                  mac_gmii_rx_dv,
    input  logic                  mac_gmii_rx_er,
    input  logic                  eth_type_arp_valid,
    input  logic [NUM_IP*32-1:0]  local_ip,
    input  logic [NUM_IP-1:0]     local_ip_en,
    arp_rx_parser_if.master       arp,
    output logic [CNT_W-1:0]      arp_drop_cnt
);
    localparam logic [4:0] LAST = 5'(ARP_LEN - 1);
    arp_state_e       state, nxt;
    logic [4:0]       cnt;
    logic [7:0]       prev;
    logic             oper_r;
    logic [47:0]      sha;
    logic [31:0]      spa;
    logic [23:0]      tpa;
    logic [31:0]      tpa_next;
    logic             acc, in_frame, hdr_bad, last, hit, grat_hit, done, drop_inc;
    logic [IDX_W-1:0] idx;

    assign acc      = mac_gmii_rx_dv && !mac_gmii_rx_er;
    assign in_frame = state == HDR || state == SENDER || state == TARGET;
    assign tpa_next = {tpa, mac_gmii_rxd};

    arp_ip_match #(.NUM_IP(NUM_IP), .IDX_W(IDX_W)) u_match (
        .tpa(tpa_next),
        .local_ip(local_ip),
        .local_ip_en(local_ip_en),
        .hit(hit),
        .idx(idx)
    );

`ifdef ARP_RX_GRATUITOUS_EN
    assign grat_hit = spa == tpa_next;
`else
    assign grat_hit = 1'b0;
`endif

    always_ff @(posedge mac_gmii_rx_clk or posedge mac_gmii_rx_rst)
        if (mac_gmii_rx_rst) state <= IDLE;
        else state <= nxt;

    always_comb begin
        nxt = IDLE;
        case (state)
            IDLE:    nxt = (acc && eth_type_arp_valid) ? HDR : IDLE;
            HDR:     nxt = !mac_gmii_rx_dv ? IDLE : (mac_gmii_rx_er || hdr_bad) ? DISCARD : cnt == 5'd7 ? SENDER : HDR;
            SENDER:  nxt = !mac_gmii_rx_dv ? IDLE : mac_gmii_rx_er ? DISCARD : cnt == 5'd17 ? TARGET : SENDER;
            TARGET:  nxt = !mac_gmii_rx_dv ? IDLE : mac_gmii_rx_er ? DISCARD : cnt == LAST ? TAIL : TARGET;
            TAIL:    nxt = mac_gmii_rx_dv ? TAIL : IDLE;
            DISCARD: nxt = mac_gmii_rx_dv ? DISCARD : IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Multi-byte header fields are checked on their final byte against the previous byte.
    always_comb begin
        hdr_bad  = state == HDR && acc && (
                   (cnt == 5'd1 && {prev, mac_gmii_rxd} != ARP_HTYPE_ETH) ||
                   (cnt == 5'd3 && {prev, mac_gmii_rxd} != ARP_PTYPE_IPV4) ||
                   (cnt == 5'd4 && mac_gmii_rxd != ARP_HLEN) ||
                   (cnt == 5'd5 && mac_gmii_rxd != ARP_PLEN) ||
                   (cnt == 5'd7 && {prev, mac_gmii_rxd} != ARP_OPER_REQ && {prev, mac_gmii_rxd} != ARP_OPER_REPLY));
        last     = state == TARGET && acc && cnt == LAST;
        done     = last && (hit || grat_hit);
        drop_inc = (in_frame && !mac_gmii_rx_dv) || (in_frame && mac_gmii_rx_dv && mac_gmii_rx_er) || hdr_bad ||
                   (last && !hit && !grat_hit) || (done && arp.arp_valid && !arp.arp_ready);
    end

    always_ff @(posedge mac_gmii_rx_clk or posedge mac_gmii_rx_rst)
        if (mac_gmii_rx_rst) cnt <= '0;
        else cnt <= (nxt == IDLE) ? 5'd0 : (acc && (state == IDLE || in_frame)) ? cnt + 5'd1 : cnt;

    always_ff @(posedge mac_gmii_rx_clk) begin
        if (acc) prev <= mac_gmii_rxd;
        if (state == HDR && acc && cnt == 5'd7) oper_r <= mac_gmii_rxd == ARP_OPER_REQ[7:0];
        if (state == SENDER && acc && cnt < 5'd14) sha <= {sha[39:0], mac_gmii_rxd};
        if (state == SENDER && acc && cnt >= 5'd14) spa <= {spa[23:0], mac_gmii_rxd};
        if (state == TARGET && acc && cnt >= 5'd24) tpa <= {tpa[15:0], mac_gmii_rxd};
    end

    // Single-entry output: a completing event loads only if the slot is empty or being drained.
    always_ff @(posedge mac_gmii_rx_clk or posedge mac_gmii_rx_rst)
        if (mac_gmii_rx_rst) begin
            arp.arp_valid  <= 1'b0;
            arp.arp_oper   <= 1'b0;
            arp.arp_sha    <= '0;
            arp.arp_spa    <= '0;
            arp.arp_ip_idx <= '0;
            arp.arp_grat   <= 1'b0;
            arp_drop_cnt   <= '0;
        end else begin
            if (done && (!arp.arp_valid || arp.arp_ready)) begin
                arp.arp_valid  <= 1'b1;
                arp.arp_oper   <= oper_r;
                arp.arp_sha    <= sha;
                arp.arp_spa    <= spa;
                arp.arp_ip_idx <= grat_hit ? '0 : idx;
                arp.arp_grat   <= grat_hit;
            end else if (arp.arp_valid && arp.arp_ready)
                arp.arp_valid <= 1'b0;
            if (drop_inc && !(&arp_drop_cnt)) arp_drop_cnt <= arp_drop_cnt + 1'b1;
        end
endmodule

// File: tb/tb_arp_rx_parser.sv
// tb_arp_rx_parser: directed ARP frames; expected events queued at stimulus, checked by a handshake monitor.
module tb_arp_rx_parser;
    typedef struct packed {
        logic        oper;
        logic [47:0] sha;
        logic [31:0] spa;
        logic        idx;
        logic        grat;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rxd = 8'h00;
    logic        dv = 1'b0, er = 1'b0, eth = 1'b0;
    logic [63:0] local_ip = '0;
    logic [1:0]  local_ip_en = '0;
    logic [15:0] drop;
    logic [1:0]  sat_drop;
    logic [7:0]  fr [28];
    ev_t         q [$];
    int          n_chk = 0, n_fail = 0, exp_drop = 0;

    arp_rx_parser_if #(.IDX_W(1)) aif ();
    arp_rx_parser_if #(.IDX_W(1)) sif ();
    assign sif.arp_ready = 1'b1;

    arp_rx_parser #(.NUM_IP(2), .CNT_W(16)) dut (
        .mac_gmii_rx_clk(clk), .mac_gmii_rx_rst(rst), .mac_gmii_rxd(rxd), .mac_gmii_rx_dv(dv),
        .mac_gmii_rx_er(er), .eth_type_arp_valid(eth), .local_ip(local_ip), .local_ip_en(local_ip_en),
        .arp(aif.master), .arp_drop_cnt(drop)
    );

    arp_rx_parser #(.NUM_IP(2), .CNT_W(2)) dut_sat (
        .mac_gmii_rx_clk(clk), .mac_gmii_rx_rst(rst), .mac_gmii_rxd(rxd), .mac_gmii_rx_dv(dv),
        .mac_gmii_rx_er(er), .eth_type_arp_valid(eth), .local_ip(local_ip), .local_ip_en(local_ip_en),
        .arp(sif.master), .arp_drop_cnt(sat_drop)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic build(input logic [15:0] htype, input logic [15:0] oper, input logic [47:0] sha,
                         input logic [31:0] spa, input logic [31:0] tpa);
        fr[0] = htype[15:8]; fr[1] = htype[7:0];
        fr[2] = 8'h08; fr[3] = 8'h00; fr[4] = 8'h06; fr[5] = 8'h04;
        fr[6] = oper[15:8]; fr[7] = oper[7:0];
        for (int i = 0; i < 6; i++) fr[8+i] = sha[47-8*i -: 8];
        for (int i = 0; i < 4; i++) fr[14+i] = spa[31-8*i -: 8];
        for (int i = 0; i < 6; i++) fr[18+i] = 8'h00;
        for (int i = 0; i < 4; i++) fr[24+i] = tpa[31-8*i -: 8];
    endtask

    task automatic send(input bit exp_ev, input ev_t ev, input int er_at, input int dv_at,
                        input int rst_at, input bit rdy_end);
        if (exp_ev) q.push_back(ev);
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (i == dv_at) begin
                dv = 1'b0; er = 1'b0; eth = 1'b0;
                break;
            end
            rxd = i < 28 ? fr[i] : 8'h55;
            dv  = 1'b1;
            er  = i == er_at;
            eth = i == 0;
            if (rdy_end && i == 27) aif.arp_ready = 1'b1;
            if (exp_ev && i == 28) chk("latency_valid", 64'(aif.arp_valid), 64'd1);
            if (i == rst_at) rst = 1'b1;
            if (i == rst_at + 1 && rst_at >= 0) begin
                chk("rst_valid", 64'(aif.arp_valid), 64'd0);
                chk("rst_fields", {15'd0, aif.arp_oper, aif.arp_sha}, 64'd0);
                chk("rst_spa_idx_grat", {30'd0, aif.arp_spa, aif.arp_ip_idx, aif.arp_grat}, 64'd0);
                chk("rst_drop", 64'(drop), 64'd0);
                chk("rst_sat_drop", 64'(sat_drop), 64'd0);
                rst = 1'b0;
            end
        end
        @(negedge clk);
        dv = 1'b0; er = 1'b0; eth = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (aif.arp_valid && aif.arp_ready) begin
                if (q.size() == 0) chk("unexpected_event", 64'(aif.arp_spa), 64'hdead);
                else begin
                    ev_t e;
                    e = q.pop_front();
                    chk("ev_oper", 64'(aif.arp_oper), 64'(e.oper));
                    chk("ev_sha", 64'(aif.arp_sha), 64'(e.sha));
                    chk("ev_spa", 64'(aif.arp_spa), 64'(e.spa));
                    chk("ev_idx", 64'(aif.arp_ip_idx), 64'(e.idx));
                    chk("ev_grat", 64'(aif.arp_grat), 64'(e.grat));
                end
            end
        end
    end

    initial begin
        ev_t none;
        none = '0;
        aif.arp_ready = 1'b1;
        local_ip    = {32'h0a000005, 32'hc0a8010a};
        local_ip_en = 2'b01;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_valid", 64'(aif.arp_valid), 64'd0);
        chk("reset_drop", 64'(drop), 64'd0);
        chk("reset_sha_spa", {aif.arp_sha[31:0], aif.arp_spa}, 64'd0);

        build(16'h0006, 16'h0001, 48'h021122334455, 32'hc0a80101, 32'hc0a8010a);
        send(1'b0, none, -1, -1, -1, 1'b0);
        build(16'h0001, 16'h0001, 48'h021122334455, 32'hc0a80101, 32'hc0a8010a);
        send(1'b0, none, 12, -1, -1, 1'b0);
        chk("drop_after_2", 64'(drop), 64'd2);
        chk("sat_after_2", 64'(sat_drop), 64'd2);
        send(1'b0, none, -1, 20, -1, 1'b0);
        build(16'h0001, 16'h0001, 48'h021122334455, 32'hc0a80101, 32'h01020304);
        send(1'b0, none, -1, -1, -1, 1'b0);
        build(16'h0006, 16'h0001, 48'h021122334455, 32'hc0a80101, 32'hc0a8010a);
        send(1'b0, none, -1, -1, -1, 1'b0);
        exp_drop = 5;
        chk("drop_after_5", 64'(drop), 64'(exp_drop));
        chk("sat_saturated", 64'(sat_drop), 64'd3);

        build(16'h0001, 16'h0001, 48'h021122334455, 32'hc0a80101, 32'hc0a8010a);
        send(1'b1, '{1'b1, 48'h021122334455, 32'hc0a80101, 1'b0, 1'b0}, -1, -1, -1, 1'b0);
        chk("drop_req", 64'(drop), 64'(exp_drop));

        local_ip    = {32'h0a000005, 32'h0a000005};
        local_ip_en = 2'b11;
        build(16'h0001, 16'h0002, 48'h0a0b0c0d0e0f, 32'h0a000001, 32'h0a000005);
        send(1'b1, '{1'b0, 48'h0a0b0c0d0e0f, 32'h0a000001, 1'b0, 1'b0}, -1, -1, -1, 1'b0);
        local_ip_en = 2'b10;
        build(16'h0001, 16'h0002, 48'h0a0b0c0d0e10, 32'h0a000002, 32'h0a000005);
        send(1'b1, '{1'b0, 48'h0a0b0c0d0e10, 32'h0a000002, 1'b1, 1'b0}, -1, -1, -1, 1'b0);

        build(16'h0001, 16'h0001, 48'h665544332211, 32'hac100009, 32'hac100009);
`ifdef ARP_RX_GRATUITOUS_EN
        send(1'b1, '{1'b1, 48'h665544332211, 32'hac100009, 1'b0, 1'b1}, -1, -1, -1, 1'b0);
`else
        send(1'b0, none, -1, -1, -1, 1'b0);
        exp_drop++;
`endif
        chk("drop_grat", 64'(drop), 64'(exp_drop));

        aif.arp_ready = 1'b0;
        build(16'h0001, 16'h0001, 48'h0000000000a1, 32'h0a0000a1, 32'h0a000005);
        send(1'b1, '{1'b1, 48'h0000000000a1, 32'h0a0000a1, 1'b1, 1'b0}, -1, -1, -1, 1'b0);
        build(16'h0001, 16'h0001, 48'h0000000000b2, 32'h0a0000b2, 32'h0a000005);
        send(1'b0, none, -1, -1, -1, 1'b0);
        exp_drop++;
        chk("bp_drop", 64'(drop), 64'(exp_drop));
        chk("bp_held_valid", 64'(aif.arp_valid), 64'd1);
        chk("bp_held_spa", 64'(aif.arp_spa), 64'h0a0000a1);
        build(16'h0001, 16'h0002, 48'h0000000000c3, 32'h0a0000c3, 32'h0a000005);
        send(1'b1, '{1'b0, 48'h0000000000c3, 32'h0a0000c3, 1'b1, 1'b0}, -1, -1, -1, 1'b1);
        chk("bp_cleared", 64'(aif.arp_valid), 64'd0);
        chk("bp_drop_final", 64'(drop), 64'(exp_drop));

        aif.arp_ready = 1'b0;
        build(16'h0001, 16'h0001, 48'h0000000000d4, 32'h0a0000d4, 32'h0a000005);
        send(1'b0, none, -1, -1, -1, 1'b0);
        chk("pre_rst_valid", 64'(aif.arp_valid), 64'd1);
        build(16'h0001, 16'h0001, 48'h0000000000e5, 32'h0a0000e5, 32'h0a000005);
        send(1'b0, none, -1, -1, 15, 1'b0);
        aif.arp_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_valid", 64'(aif.arp_valid), 64'd0);
        chk("post_rst_drop", 64'(drop), 64'd0);
        chk("queue_empty", 64'(q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
